// File: rtl/out_port_uart_tx.sv
// Watches the CPU output port for value changes, queues each new byte in a
// small FIFO and serialises it as UART 8N1 on tx; done flags a fully drained halt.
module out_port_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    port_data,
    input  logic                          halted,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          done
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [2:0]          bit_q, bit_d;
    logic [7:0]          shift_q, shift_d;
    logic                tx_q, tx_d;
    logic                busy_q;

    logic [7:0]          last_value_q;
    logic [7:0]          mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                overflow_q;

    logic                change;
    logic                full;
    logic                pop;
    logic                push_ok;
    logic                drop;
    logic                baud_last;
    logic                fifo_nonempty;

    assign change        = (port_data != last_value_q);
    assign full          = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_nonempty = (count_q != '0);
    assign push_ok       = change && (!full || pop);
    assign drop          = change && full && !pop;
    assign count_d       = count_q + CNT_W'(push_ok) - CNT_W'(pop);
    assign baud_last     = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

    // Transmit FSM next-state and pop decision
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (fifo_nonempty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    baud_d  = '0;
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = shift_q[bit_q + 3'd1];
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    // Back-to-back frame when another byte is already waiting
                    if (fifo_nonempty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        state_d = START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            baud_q       <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            last_value_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            baud_q       <= baud_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            tx_q         <= tx_d;
            busy_q       <= (state_d != IDLE);
            last_value_q <= port_data;
            count_q      <= count_d;
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Storage needs no reset; pointers alone define the contents
    always_ff @(posedge clk) begin
        if (rst_n && push_ok) begin
            mem_q[wr_ptr_q] <= port_data;
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    assign done       = halted && (count_q == '0) && !busy_q;

endmodule

// File: tb/tb_out_port_uart_tx.sv
// Scoreboard bench for out_port_uart_tx: a queue-level model predicts frames
// and status; a UART monitor decodes tx and checks each frame against it.
module tb_out_port_uart_tx;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 4;
    localparam int          FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] port_data;
    logic       halted;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_count;
    logic       overflow;
    logic       done;

    out_port_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .port_data  (port_data),
        .halted     (halted),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         edge_n;
    } exp_t;

    exp_t       exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         edge_num = 0;
    int         last_rst_edge = -1;

    // Reference model: byte queue, sticky overflow, transmitter free time
    logic [7:0] m_q[$];
    logic [7:0] m_last = 8'h00;
    bit         m_ovf = 1'b0;
    int         m_busy_until = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", name, edge_num, act, req);
        end
    endtask

    task automatic model_edge();
        int n;
        n = edge_num + 1;
        if (!rst_n) begin
            m_q.delete();
            m_last       = 8'h00;
            m_ovf        = 1'b0;
            m_busy_until = 0;
            last_rst_edge = n;
            while (exp_q.size() > 0 && exp_q[exp_q.size()-1].edge_n + FRAME > n)
                void'(exp_q.pop_back());
            return;
        end
        if (m_q.size() > 0 && n >= m_busy_until) begin
            exp_t e;
            e.data   = m_q.pop_front();
            e.edge_n = n;
            exp_q.push_back(e);
            m_busy_until = n + FRAME;
        end
        if (port_data != m_last) begin
            if (m_q.size() < DEPTH) m_q.push_back(port_data);
            else m_ovf = 1'b1;
            m_last = port_data;
        end
    endtask

    task automatic check_status();
        logic       exp_busy;
        logic       exp_done;
        logic [2:0] exp_cnt;
        exp_busy = (edge_num < m_busy_until);
        exp_cnt  = 3'(m_q.size());
        exp_done = halted && (m_q.size() == 0) && !exp_busy;
        check("status{cnt,ovf,busy,done}",
              {26'd0, fifo_count, overflow, busy, done},
              {26'd0, exp_cnt, m_ovf, exp_busy, exp_done});
        if (!exp_busy) check("tx_idle", {31'd0, tx}, 32'd1);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        edge_num++;
        #1;
        check_status();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic drain(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (m_q.size() == 0 && edge_num >= m_busy_until && exp_q.size() == 0) break;
            step();
        end
        if (i == budget) check("drain_timeout", 32'd1, 32'd0);
        run(3);
    endtask

    // UART monitor: decodes every frame on tx and scores it
    bit         in_frame = 1'b0;
    int         fr_start;
    int         fr_pos;
    int         slot;
    logic [7:0] fr_bits;
    bit         fr_bad;
    exp_t       fr_exp;

    always @(negedge clk) begin
        if (in_frame && last_rst_edge > fr_start && edge_num >= last_rst_edge) in_frame = 1'b0;
        if (!in_frame && tx === 1'b0) begin
            in_frame = 1'b1;
            fr_start = edge_num;
            fr_pos   = 0;
            fr_bits  = 8'h00;
            fr_bad   = 1'b0;
        end
        if (in_frame) begin
            slot = fr_pos / CPB;
            if (slot == 0) begin
                if (tx !== 1'b0) fr_bad = 1'b1;
            end else if (slot == 9) begin
                if (tx !== 1'b1) fr_bad = 1'b1;
            end else if (fr_pos % CPB == 0) begin
                fr_bits[slot-1] = tx;
            end else if (tx !== fr_bits[slot-1]) begin
                fr_bad = 1'b1;
            end
            if (busy !== 1'b1) fr_bad = 1'b1;
            fr_pos++;
            if (fr_pos == FRAME) begin
                in_frame = 1'b0;
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", {24'd0, fr_bits}, 32'hFFFF_FFFF);
                end else begin
                    fr_exp = exp_q.pop_front();
                    check("frame_data", {24'd0, fr_bits}, {24'd0, fr_exp.data});
                    check("frame_start_edge", 32'(fr_start), 32'(fr_exp.edge_n));
                    check("frame_shape", {31'd0, fr_bad}, 32'd0);
                end
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        port_data = 8'h00;
        halted    = 1'b0;
        run(2);
        check("reset_tx", {31'd0, tx}, 32'd1);
        rst_n = 1'b1;
        run(2);

        // Single byte
        port_data = 8'hA5;
        drain(200);

        // Back-to-back frames
        port_data = 8'h01; step();
        port_data = 8'h02; step();
        port_data = 8'h03; step();
        drain(400);

        // Overflow burst
        for (int v = 8'h10; v <= 8'h16; v++) begin
            port_data = 8'(v);
            step();
        end
        drain(600);

        // Repeat and zero suppression after a fresh reset
        rst_n = 1'b0; port_data = 8'h00; step();
        rst_n = 1'b1; step();
        port_data = 8'h55; run(100);
        port_data = 8'h55; drain(200);

        // Reset during DATA bit 3 with two bytes queued
        port_data = 8'hFF; step();
        port_data = 8'h11; step();
        port_data = 8'h22; step();
        run(16);
        rst_n = 1'b0; port_data = 8'h00; step();
        check("midframe_reset_tx", {31'd0, tx}, 32'd1);
        rst_n = 1'b1;
        run(60);

        // Done with two frames pending, then release halted
        halted = 1'b1;
        port_data = 8'h31; step();
        port_data = 8'h32; step();
        drain(300);
        halted = 1'b0;
        #1;
        check("done_follows_halted", {31'd0, done}, 32'd0);
        run(2);

        // Randomised bursts, gaps, halts and occasional resets
        for (int b = 0; b < 40; b++) begin
            int k;
            int gap;
            k = $urandom_range(1, 6);
            for (int i = 0; i < k; i++) begin
                if ($urandom_range(0, 4) != 0) port_data = 8'($urandom);
                step();
            end
            halted = 1'($urandom_range(0, 1));
            gap = $urandom_range(0, 200);
            run(gap / 2);
            if ($urandom_range(0, 7) == 0) begin
                rst_n = 1'b0; step();
                rst_n = 1'b1;
            end
            run(gap - gap / 2);
        end
        drain(800);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
